// File: rtl/tff_count_ctrl_pkg.sv
// Shared constants for the toggle-chain counter controller.
package tff_count_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/tff_chain_counter.sv
// Synchronous toggle-chain counter: stage i toggles when En and all lower bits are 1.
module tff_chain_counter
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Ripple the toggle enable up through the chain; each stage is a T flop.
  always_comb begin
    logic carry;
    q_d   = q_q;
    carry = En;
    for (int i = 0; i < WIDTH; i++) begin
      q_d[i] = q_q[i] ^ carry;
      carry  = carry & q_q[i];
    end
  end

  // Clear dominates; otherwise take the toggled value.
  always_ff @(posedge Clk) begin
    if (Clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencing controller for the toggle-chain counter: one-shot / auto-reload runs
// with pause and single-step for board debug.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no run active, counter held
//   RUN   | counting toward term_q
//   PAUSE | run frozen; Step performs one terminal-check action
//   DONE  | one-shot run finished, Q holds term_q until next Start
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Pause,
  input  logic             Step,
  input  logic             Reload,
  input  logic [WIDTH-1:0] Term,
  output logic [WIDTH-1:0] Q,
  output logic             CntEn,
  output logic             Busy,
  output logic             Done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;

  logic             cnt_en;
  logic             restart;
  logic             reload_wrap;
  logic             advance;
  logic [WIDTH-1:0] q;

  // Next-state, counter enable and clear requests; Abort > Start > Pause > Step.
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    reload_d    = reload_q;
    done_d      = 1'b0;
    cnt_en      = 1'b0;
    restart     = 1'b0;
    reload_wrap = 1'b0;
    advance     = 1'b0;

    if (!Clr) begin
      if (Abort) begin
        state_d = ST_IDLE;
        restart = 1'b1;
      end else if (Start) begin
        term_d   = Term;
        reload_d = Reload;
        restart  = 1'b1;
        if (Term == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (Pause) state_d = ST_PAUSE;
            else       advance = 1'b1;
          end
          ST_PAUSE: begin
            if (!Pause)    state_d = ST_RUN;
            else if (Step) advance = 1'b1;
          end
          default: ;
        endcase
      end

      // Shared terminal-check action for a running cycle or a single step.
      if (advance) begin
        if (q != term_q) begin
          cnt_en = 1'b1;
        end else if (reload_q) begin
          reload_wrap = 1'b1;
          done_d      = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // Controller registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q  <= ST_IDLE;
      term_q   <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      term_q   <= term_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  tff_chain_counter #(
    .WIDTH(WIDTH)
  ) u_chain (
    .Clk (Clk),
    .Clr (Clr | restart | reload_wrap),
    .En  (cnt_en),
    .Q   (q)
  );

  assign Q     = q;
  assign CntEn = cnt_en;
  assign Busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign Done  = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed vectors with hand-computed expectations, checked by a decoupled scoreboard monitor.
module tb_tff_count_ctrl;

  logic       clk;
  logic       clr, start, abort, pause, step, reload;
  logic [3:0] term;
  logic [3:0] q;
  logic       cnt_en, busy, done;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       cen;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   vidx     = 0;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .Clk    (clk),
    .Clr    (clr),
    .Start  (start),
    .Abort  (abort),
    .Pause  (pause),
    .Step   (step),
    .Reload (reload),
    .Term   (term),
    .Q      (q),
    .CntEn  (cnt_en),
    .Busy   (busy),
    .Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic vec(input logic c, s, a, p, st, r, input logic [3:0] t,
                     input logic [3:0] eq, input logic eb, ed, ec);
    exp_t e;
    @(negedge clk);
    clr = c; start = s; abort = a; pause = p; step = st; reload = r; term = t;
    e.idx = vidx; e.q = eq; e.busy = eb; e.done = ed; e.cen = ec;
    sb.push_back(e);
    vidx++;
  endtask

  task automatic idle(input logic [3:0] eq, input logic eb, ed, ec);
    vec(0, 0, 0, 0, 0, 0, 4'd0, eq, eb, ed, ec);
  endtask

  // Monitor: CntEn is checked before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (cnt_en !== e.cen) begin
          failures++;
          $display("FAIL vec%0d cnt_en: got %b expected %b", e.idx, cnt_en, e.cen);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q !== e.q) begin
          failures++;
          $display("FAIL vec%0d q: got %0d expected %0d", e.idx, q, e.q);
        end
        checks++;
        if (busy !== e.busy) begin
          failures++;
          $display("FAIL vec%0d busy: got %b expected %b", e.idx, busy, e.busy);
        end
        checks++;
        if (done !== e.done) begin
          failures++;
          $display("FAIL vec%0d done: got %b expected %b", e.idx, done, e.done);
        end
      end
    end
  end

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; step = 1'b0; reload = 1'b0; term = 4'd0;

    // Reset with Start held: Clr wins.
    vec(1, 1, 0, 0, 0, 0, 4'd5, 4'd0, 0, 0, 0);
    vec(1, 1, 0, 0, 0, 0, 4'd5, 4'd0, 0, 0, 0);

    // One-shot to 5.
    vec(0, 1, 0, 0, 0, 0, 4'd5, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) idle(4'(i), 1, 0, 1);
    idle(4'd5, 0, 1, 0);
    for (int i = 0; i < 10; i++) idle(4'd5, 0, 0, 0);
    vec(0, 0, 0, 1, 1, 0, 4'd0, 4'd5, 0, 0, 0);

    // Auto-reload to 3, two full periods.
    vec(0, 1, 0, 0, 0, 1, 4'd3, 4'd0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 3; i++) idle(4'(i), 1, 0, 1);
      idle(4'd0, 1, 1, 0);
    end

    // Pause and single-step, then resume.
    vec(0, 1, 0, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0);
    idle(4'd1, 1, 0, 1);
    idle(4'd2, 1, 0, 1);
    vec(0, 0, 0, 1, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    vec(0, 0, 0, 1, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    vec(0, 0, 0, 1, 1, 0, 4'd0, 4'd3, 1, 0, 1);
    vec(0, 0, 0, 1, 0, 0, 4'd0, 4'd3, 1, 0, 0);
    vec(0, 0, 0, 1, 1, 0, 4'd0, 4'd4, 1, 0, 1);
    vec(0, 0, 0, 1, 1, 0, 4'd0, 4'd5, 1, 0, 1);
    vec(0, 0, 0, 1, 0, 0, 4'd0, 4'd5, 1, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 4'd0, 4'd5, 1, 0, 0);
    idle(4'd6, 1, 0, 1);
    vec(0, 0, 0, 0, 1, 0, 4'd0, 4'd7, 1, 0, 1);

    // One-shot Term=4: step at the terminal ends the run.
    vec(0, 1, 0, 0, 0, 0, 4'd4, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) idle(4'(i), 1, 0, 1);
    vec(0, 0, 0, 1, 0, 0, 4'd0, 4'd4, 1, 0, 0);
    vec(0, 0, 0, 1, 1, 0, 4'd0, 4'd4, 0, 1, 0);
    vec(0, 0, 0, 1, 1, 0, 4'd0, 4'd4, 0, 0, 0);

    // Restart mid-run with a shorter term.
    vec(0, 1, 0, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) idle(4'(i), 1, 0, 1);
    vec(0, 1, 0, 0, 0, 0, 4'd2, 4'd0, 1, 0, 0);
    idle(4'd1, 1, 0, 1);
    idle(4'd2, 1, 0, 1);
    idle(4'd2, 0, 1, 0);
    idle(4'd2, 0, 0, 0);

    // Abort together with Start.
    vec(0, 1, 0, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0);
    idle(4'd1, 1, 0, 1);
    idle(4'd2, 1, 0, 1);
    vec(0, 1, 1, 0, 0, 0, 4'd3, 4'd0, 0, 0, 0);
    idle(4'd0, 0, 0, 0);
    idle(4'd0, 0, 0, 0);

    // Term=0 goes straight to DONE.
    vec(0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    idle(4'd0, 0, 0, 0);

    // Term=15 one-shot reaches full scale without wrapping.
    vec(0, 1, 0, 0, 0, 0, 4'd15, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 15; i++) idle(4'(i), 1, 0, 1);
    idle(4'd15, 0, 1, 0);
    idle(4'd15, 0, 0, 0);

    // Clr mid-run at Q=7.
    vec(0, 1, 0, 0, 0, 0, 4'd12, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) idle(4'(i), 1, 0, 1);
    vec(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    idle(4'd0, 0, 0, 0);

    // Let the monitor drain; a stuck queue counts as a failure.
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
